alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU: same 3-bit opcode set widened to WIDTH bits.
- Adds a valid/ready handshake on input and output, a multi-cycle shift-add multiplier, an accumulator operand mode and a 4-bit status flag.
- Sits between an operand source (register file or sequencer) and a result sink that may apply backpressure.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A, ignored when acc_en=1.
- B  input  WIDTH  operand B.
- opcode  input  3  operation select.
- acc_en  input  1  use the accumulator as operand A.
- acc_clr  input  1  clear the accumulator.
- out_valid  output  1  res/flag valid.
- out_ready  input  1  sink accepts the result.
- res  output  WIDTH  result.
- flag  output  4  {N,V,Z,C}.

Behaviour:
- Reset is asynchronous, active-high, and the only asynchronous path.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, res=0, flag=0, acc=0.
  - Reset asserted mid-operation aborts it; no result is produced.
- Acceptance occurs on a rising edge with in_valid && in_ready.
  - A (or acc), B, opcode are captured at that edge.
  - They are not re-sampled afterwards.
- Opcodes:
  - 000 ADD A+B.
  - 001 SUB A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL A by B[SHW-1:0].
  - 111 MUL, low WIDTH bits of A*B, unsigned.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On accepting a non-MUL opcode, compute and register res/flag, then go to DONE. out_valid=1 on the cycle after acceptance (latency 1).
  - IDLE: on accepting MUL, load the multiplicand, multiplier and a 2*WIDTH-bit partial product (0), then go to MUL.
  - MUL: in_ready=0. Run one shift-add iteration per cycle, WIDTH iterations, via an internal counter. After the final iteration, register res/flag and go to DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1, in_ready=0. res/flag are held stable until out_valid && out_ready. On that edge out_valid drops and the FSM returns to IDLE.
  - No same-cycle re-accept: minimum issue interval is 2 cycles for single-cycle ops.
- Flags:
  - Z = (res==0).
  - N = res[WIDTH-1].
  - C:
    - ADD: carry-out.
    - SUB: carry-out of A+~B+1 (1 = no borrow).
    - SHL: last bit shifted out; 0 if the shift amount is 0.
    - MUL: 1 if product[2*WIDTH-1:WIDTH] is nonzero.
    - Logic ops: 0.
  - V: two's-complement overflow for ADD/SUB; 0 for all other ops.
- Accumulator:
  - acc is loaded with res on the same edge that res is registered.
  - acc_clr is synchronous and acts only when state=IDLE.
  - acc_clr together with acc_en at acceptance: operand A = 0, and acc takes the new result.
  - acc_clr outside IDLE is ignored.
- in_valid while in_ready=0 is ignored (no queuing). The source must hold the request until accepted.

Test Plan:
- WIDTH=4, ADD A=1001 B=1001 -> one cycle later out_valid=1, res=0010, flag={N0,V1,Z0,C1}. Holds until out_ready=1.
- SUB A=1001 B=1001 -> res=0000, flag={0,0,1,1}. SHL A=0011 B=0011 -> res=1000, C=1.
- MUL A=0101 B=0011 -> in_ready=0 for 4 MUL cycles; out_valid on cycle 5 after acceptance; res=1111, C=0. MUL A=1001 B=1001 -> res=0001, C=1.
- Backpressure: ADD result with out_ready=0 for 3 cycles -> res/flag/out_valid stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
- Accumulator chain: acc_clr+acc_en ADD B=0011 -> res=0011; then acc_en ADD B=0011 -> res=0110; then acc_en SUB B=0110 -> res=0000, Z=1.
- Assert rst during cycle 2 of a MUL -> out_valid=0, in_ready=1, res=0, flag=0, acc=0 immediately. A new ADD 0001+0001 afterwards returns 0010.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered WIDTH-bit ALU with valid/ready handshakes, a
//                multi-cycle shift-add multiplier, an accumulator operand
//                mode and {N,V,Z,C} status flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Iteration counter only needs to reach WIDTH-1
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_accept;
  logic               w_mul_last;

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [3:0]         w_alu_flag;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   w_mul_res;
  logic [3:0]         w_mul_flag;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (opcode == OP_MUL) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Single-cycle ALU on the accepted operands; acc_clr with acc_en forces A=0
  always_comb begin
    w_opa     = acc_en ? (acc_clr ? '0 : r_acc) : A;
    w_add     = {1'b0, w_opa} + {1'b0, B};
    w_sub     = {1'b0, w_opa} + {1'b0, ~B} + (WIDTH+1)'(1);
    // Extra top bit catches the last bit shifted out (0 for a zero shift)
    w_shl     = {1'b0, w_opa} << B[SHW-1:0];
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_c   = w_add[WIDTH];
        w_alu_v   = (w_opa[WIDTH-1] == B[WIDTH-1]) &&
                    (w_add[WIDTH-1] != w_opa[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_c   = w_sub[WIDTH];
        w_alu_v   = (w_opa[WIDTH-1] != B[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != w_opa[WIDTH-1]);
      end
      OP_AND:  w_alu_res = w_opa & B;
      OP_OR:   w_alu_res = w_opa | B;
      OP_XOR:  w_alu_res = w_opa ^ B;
      OP_NOT:  w_alu_res = ~w_opa;
      OP_SHL: begin
        w_alu_res = w_shl[WIDTH-1:0];
        w_alu_c   = w_shl[WIDTH];
      end
      default: w_alu_res = '0;
    endcase
    w_alu_flag = {w_alu_res[WIDTH-1], w_alu_v, (w_alu_res == '0), w_alu_c};
  end

  // Shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    w_mul_res  = w_prod_nxt[WIDTH-1:0];
    w_mul_flag = {w_mul_res[WIDTH-1], 1'b0, (w_mul_res == '0),
                  |w_prod_nxt[2*WIDTH-1:WIDTH]};
  end

  // Datapath registers: result, flags, accumulator and multiplier state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res      <= '0;
      flag     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (acc_clr) begin
            r_acc <= '0;
          end
          if (w_accept) begin
            if (opcode == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_opa};
              r_mplier <= B;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              res   <= w_alu_res;
              flag  <= w_alu_flag;
              r_acc <= w_alu_res;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_mul_last) begin
            res   <= w_mul_res;
            flag  <= w_mul_flag;
            r_acc <= w_mul_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   opcode;
  logic         acc_en;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [3:0]   flag;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .flag     (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one request, hold it across one edge, then wait for the result
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic en, input logic clr,
                       input int exp_lat, input logic [W-1:0] exp_res,
                       input logic [3:0] exp_flag);
    int lat;
    check_eq({tag, " ready"}, in_ready, 1);
    A = a; B = b; opcode = op; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    A = '0; B = '0; opcode = '0;
    if (op == 3'b111) check_eq({tag, " busy"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " lat"}, lat, exp_lat);
    check_eq({tag, " res"}, res, exp_res);
    check_eq({tag, " flag"}, flag, exp_flag);
  endtask

  // Accept the pending result and confirm return to IDLE
  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " pop ov"}, out_valid, 0);
    check_eq({tag, " pop rdy"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; A = '0; B = '0; opcode = '0;
    acc_en = 0; acc_clr = 0; out_ready = 0;
    #2;
    check_eq("rst in_ready", in_ready, 1);
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst res", res, 0);
    check_eq("rst flag", flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with overflow and carry, held while sink stalls
    issue("add", 4'b1001, 4'b1001, 3'b000, 0, 0, 1, 4'b0010, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 4'b0001; B = 4'b0001; opcode = 3'b001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("bp ov", out_valid, 1);
      check_eq("bp rdy", in_ready, 0);
      check_eq("bp res", res, 4'b0010);
      check_eq("bp flag", flag, 4'b0101);
    end
    pop("add");
    @(posedge clk); #1;
    check_eq("no queue ov", out_valid, 0);

    issue("sub", 4'b1001, 4'b1001, 3'b001, 0, 0, 1, 4'b0000, 4'b0011);
    pop("sub");
    issue("shl", 4'b0011, 4'b0011, 3'b110, 0, 0, 1, 4'b1000, 4'b1001);
    pop("shl");
    issue("shl0", 4'b0110, 4'b0000, 3'b110, 0, 0, 1, 4'b0110, 4'b0000);
    pop("shl0");
    issue("and", 4'b1100, 4'b1010, 3'b010, 0, 0, 1, 4'b1000, 4'b1000);
    pop("and");
    issue("or", 4'b0100, 4'b0010, 3'b011, 0, 0, 1, 4'b0110, 4'b0000);
    pop("or");
    issue("xor", 4'b1111, 4'b1111, 3'b100, 0, 0, 1, 4'b0000, 4'b0010);
    pop("xor");
    issue("not", 4'b0101, 4'b0000, 3'b101, 0, 0, 1, 4'b1010, 4'b1000);
    pop("not");
    issue("subv", 4'b0111, 4'b1000, 3'b001, 0, 0, 1, 4'b1111, 4'b1100);
    pop("subv");
    issue("mul1", 4'b0101, 4'b0011, 3'b111, 0, 0, 5, 4'b1111, 4'b1000);
    pop("mul1");
    issue("mul2", 4'b1001, 4'b1001, 3'b111, 0, 0, 5, 4'b0001, 4'b0001);
    pop("mul2");

    // Accumulator chain
    issue("acc1", 4'b1111, 4'b0011, 3'b000, 1, 1, 1, 4'b0011, 4'b0000);
    pop("acc1");
    issue("acc2", 4'b1111, 4'b0011, 3'b000, 1, 0, 1, 4'b0110, 4'b0000);
    pop("acc2");
    issue("acc3", 4'b1111, 4'b0110, 3'b001, 1, 0, 1, 4'b0000, 4'b0011);
    pop("acc3");
    issue("accmul", 4'b0000, 4'b0011, 3'b111, 1, 1, 5, 4'b0000, 4'b0010);
    pop("accmul");

    // Reset during the second MUL cycle
    issue("pre", 4'b0011, 4'b0100, 3'b000, 0, 0, 1, 4'b0111, 4'b0000);
    pop("pre");
    A = 4'b0111; B = 4'b0111; opcode = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("arst ov", out_valid, 0);
    check_eq("arst rdy", in_ready, 1);
    check_eq("arst res", res, 0);
    check_eq("arst flag", flag, 0);
    check_eq("arst acc", dut.r_acc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("arst idle ov", out_valid, 0);
    issue("post", 4'b0001, 4'b0001, 3'b000, 0, 0, 1, 4'b0010, 4'b0000);
    pop("post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
